// File: rtl/pwm_capture.sv
// PWM input capture: measures high time and period of an external PWM signal
// in system clock cycles, exposed through a small chip-select register bus.
module pwm_capture #(
    parameter int CNT_W = 16
) (
    input  logic        i_sys_clk,
    input  logic        i_rst,
    input  logic        i_cs,
    input  logic        i_rd,
    input  logic [1:0]  i_addr,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    input  logic        i_pwm_in,
    output logic        o_cap_valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_next;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic             r_en;
    logic             r_valid;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_high_shadow;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_rise;
    logic             w_fall;
    logic             w_wr_ctrl;
    logic             w_clr;
    logic             w_rd;
    logic             w_rd_period;
    logic             w_capture_high;
    logic             w_publish;
    logic             w_unused;

    assign w_rise      = r_sync2 & ~r_prev;
    assign w_fall      = ~r_sync2 & r_prev;
    assign w_wr_ctrl   = i_cs & ~i_rd & (i_addr == 2'd0);
    assign w_clr       = w_wr_ctrl & i_wdata[1];
    assign w_rd        = i_cs & i_rd;
    assign w_rd_period = w_rd & (i_addr == 2'd2);
    assign w_cnt_inc   = (r_cnt == CNT_MAX) ? CNT_MAX : (r_cnt + CNT_ONE);
    assign w_unused    = ^i_wdata[15:2];
    assign o_cap_valid = r_valid;

    // Next-state and counter control; clr overrides everything, then enable.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_capture_high = 1'b0;
        w_publish      = 1'b0;
        if (w_clr) begin
            w_state_next = i_wdata[0] ? ST_ARM : ST_IDLE;
            w_cnt_next   = '0;
        end else if (!r_en) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_ARM;
                    w_cnt_next   = '0;
                end
                ST_ARM: begin
                    if (w_rise) begin
                        w_state_next = ST_HIGH;
                        w_cnt_next   = CNT_ONE;
                    end else begin
                        w_state_next = ST_ARM;
                        w_cnt_next   = '0;
                    end
                end
                ST_HIGH: begin
                    w_cnt_next = w_cnt_inc;
                    if (w_fall) begin
                        w_state_next   = ST_LOW;
                        w_capture_high = 1'b1;
                    end else begin
                        w_state_next = ST_HIGH;
                    end
                end
                ST_LOW: begin
                    if (w_rise) begin
                        w_state_next = ST_HIGH;
                        w_cnt_next   = CNT_ONE;
                        w_publish    = 1'b1;
                    end else begin
                        w_state_next = ST_LOW;
                        w_cnt_next   = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Input synchronizer, edge-detect flop and measurement counter.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_pwm_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_cnt   <= w_cnt_next;
        end
    end

    // Control and result registers; a publish beats a PERIOD read on valid.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_en          <= 1'b0;
            r_valid       <= 1'b0;
            r_ovf         <= 1'b0;
            r_high_shadow <= '0;
            r_high        <= '0;
            r_period      <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_en <= i_wdata[0];
            end
            if (w_clr) begin
                r_valid       <= 1'b0;
                r_ovf         <= 1'b0;
                r_high_shadow <= '0;
                r_high        <= '0;
                r_period      <= '0;
            end else begin
                if (w_capture_high) begin
                    r_high_shadow <= r_cnt;
                end
                if (w_publish) begin
                    r_high   <= r_high_shadow;
                    r_period <= r_cnt;
                    r_valid  <= 1'b1;
                end else if (w_rd_period) begin
                    r_valid <= 1'b0;
                end
                if (w_cnt_next == CNT_MAX) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    // Registered read data, held when no read is in progress.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            o_rdata <= 16'd0;
        end else if (w_rd) begin
            case (i_addr)
                2'd0:    o_rdata <= {15'd0, r_en};
                2'd1:    o_rdata <= 16'(r_high);
                2'd2:    o_rdata <= 16'(r_period);
                2'd3:    o_rdata <= {14'd0, r_ovf, r_valid};
                default: o_rdata <= 16'd0;
            endcase
        end
    end

endmodule
